// File: rtl/adder_slice_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// adder_slice_sequencer_pkg
// Shared definitions for the slice-sequenced adder:
//   - FSM state encoding (IDLE / RUN / DONE)
//   - default operand width and slice width
//   - derived slice count and counter width, plus a helper that sizes the
//     slice counter for any WIDTH/SLICE combination
// -----------------------------------------------------------------------------
package adder_slice_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_SLICE = 4;
  localparam int DEF_N     = DEF_WIDTH / DEF_SLICE;
  localparam int DEF_CNT_W = $clog2(DEF_N);

  // Counter width for n slices; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/full_adder_4bit.sv
// -----------------------------------------------------------------------------
// full_adder_4bit
// Plain 4-bit ripple-carry adder slice; the only arithmetic resource of the
// sequencer, reused once per clock.
// Ports:
//   a, b  in  4  slice operands
//   ci    in  1  carry in
//   s     out 4  slice sum
//   co    out 1  carry out of bit 3
// -----------------------------------------------------------------------------
module full_adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  // Ripple the carry through four full-adder cells.
  always_comb begin
    logic c;
    s = 4'b0000;
    c = ci;
    for (int i = 0; i < 4; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end

endmodule

// File: rtl/adder_slice_sequencer.sv
// -----------------------------------------------------------------------------
// adder_slice_sequencer
// Multi-cycle WIDTH-bit adder that runs one shared SLICE-bit ripple slice per
// clock from the LSB slice upwards, keeping the carry in a register between
// slices. Operands enter through a valid/ready handshake in IDLE; the result
// leaves through a second valid/ready handshake in DONE.
//
// Optional feature macro: ADDSEQ_SUB_EN
//   defined   -> op_sub port exists; op_sub=1 computes x-y (c_out=1: no borrow)
//   undefined -> add-only, op_sub port absent
//
// Ports:
//   clk        in   1      rising-edge clock
//   reset      in   1      asynchronous active-high reset
//   in_valid   in   1      operands and c_in valid
//   in_ready   out  1      operands accepted (high only in IDLE)
//   x, y       in   WIDTH  operands
//   c_in       in   1      carry into bit 0
//   op_sub     in   1      subtract select (ADDSEQ_SUB_EN only)
//   out_valid  out  1      sum/c_out valid (DONE)
//   out_ready  in   1      consumer accepts result
//   sum        out  WIDTH  result, modulo 2^WIDTH
//   c_out      out  1      carry out of bit WIDTH-1
//
// SLICE must be 4 to match the shared full_adder_4bit slice.
// -----------------------------------------------------------------------------
module adder_slice_sequencer
  import adder_slice_sequencer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             c_in,
`ifdef ADDSEQ_SUB_EN
  input  logic             op_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  localparam int N     = WIDTH / SLICE;
  localparam int CNT_W = cnt_width(N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  state_t             state_r;
  state_t             state_next_s;
  logic               load_s;
  logic               step_s;
  logic               last_s;
  logic [WIDTH-1:0]   b_load_s;
  logic               carry_load_s;

  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [WIDTH-1:0]   sum_r;
  logic               carry_r;
  logic               c_out_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               in_ready_r;
  logic               out_valid_r;

  logic [SLICE-1:0]   slice_sum_s;
  logic               slice_co_s;

  full_adder_4bit u_slice (
    .a  (a_r[SLICE-1:0]),
    .b  (b_r[SLICE-1:0]),
    .ci (carry_r),
    .s  (slice_sum_s),
    .co (slice_co_s)
  );

  // Operand conditioning on accept: subtraction is x + ~y + 1.
  always_comb begin
    b_load_s     = y;
    carry_load_s = c_in;
`ifdef ADDSEQ_SUB_EN
    if (op_sub) begin
      b_load_s     = ~y;
      carry_load_s = 1'b1;
    end else begin
      b_load_s     = y;
      carry_load_s = c_in;
    end
`endif
  end

  // Next-state and datapath control decode.
  always_comb begin
    state_next_s = state_r;
    load_s       = 1'b0;
    step_s       = 1'b0;
    last_s       = (cnt_r == CNT_LAST);
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          load_s       = 1'b1;
          state_next_s = RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        step_s = 1'b1;
        if (last_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DONE;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Handshake flags registered from the next state so they track state_r.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      in_ready_r  <= (state_next_s == IDLE);
      out_valid_r <= (state_next_s == DONE);
    end
  end

  // Operand/sum shift registers, carry register, slice counter, carry out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      sum_r   <= {WIDTH{1'b0}};
      carry_r <= 1'b0;
      c_out_r <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
    end else if (load_s) begin
      a_r     <= x;
      b_r     <= b_load_s;
      sum_r   <= {WIDTH{1'b0}};
      carry_r <= carry_load_s;
      cnt_r   <= {CNT_W{1'b0}};
    end else if (step_s) begin
      // Slice results enter at the MSB end; after N steps slice 0 sits at LSB.
      a_r     <= {{SLICE{1'b0}}, a_r[WIDTH-1:SLICE]};
      b_r     <= {{SLICE{1'b0}}, b_r[WIDTH-1:SLICE]};
      sum_r   <= {slice_sum_s, sum_r[WIDTH-1:SLICE]};
      carry_r <= slice_co_s;
      cnt_r   <= cnt_r + CNT_W'(1);
      if (last_s) begin
        c_out_r <= slice_co_s;
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign sum       = sum_r;
  assign c_out     = c_out_r;

endmodule
